// File: rtl/conv_feeder.sv
// conv_feeder: streams binary pixels into a bank of channel images and hands
// them to a convolution core. It then captures the core's feature map and
// holds it until the consumer acknowledges it. The core is watched with a
// timeout, and a missed deadline is reported through a sticky error flag.
module conv_feeder #(
    parameter int IC           = 8,
    parameter int IMG_IN_SIZE  = 30,
    parameter int IMG_OUT_SIZE = IMG_IN_SIZE - 2,
    parameter int TIMEOUT      = IC * 10 * IMG_OUT_SIZE * IMG_OUT_SIZE + 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pix_valid,
    input  logic                                   pix_in,
    output logic                                   pix_ready,
    output logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]     img_in [IC],
    output logic                                   data_in_ready,
    input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]   core_img_out,
    input  logic                                   core_done,
    output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]   result,
    output logic                                   result_valid,
    input  logic                                   result_ack,
    output logic                                   timeout_err
);

    localparam int N  = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (IC > 1) ? $clog2(IC) : 1;
    localparam int RW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {LOAD, RUN, HOLD} state_t;

    state_t        state, state_next;
    logic [PW-1:0] pix_cnt;
    logic [CW-1:0] ch_cnt;
    logic [RW-1:0] run_cnt;

    logic xfer, last_pix, last_ch, last_xfer, run_expired;

    assign xfer        = pix_valid && pix_ready;
    assign last_pix    = (pix_cnt == PW'(N - 1));
    assign last_ch     = (ch_cnt == CW'(IC - 1));
    assign last_xfer   = xfer && last_pix && last_ch;
    // The counter reads TIMEOUT-1 during the TIMEOUT-th cycle of RUN.
    assign run_expired = (run_cnt == RW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    // Next-state logic. Inside RUN, core_done is tested before the timeout,
    // so a result that arrives on the deadline cycle is still taken.
    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        case (state)
            LOAD: begin
                pix_ready = 1'b1;
                if (last_xfer) state_next = RUN;
            end
            RUN: begin
                if (core_done)        state_next = HOLD;
                else if (run_expired) state_next = LOAD;
            end
            HOLD: begin
                if (result_ack) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // Datapath: pixel capture, run watchdog, result capture and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt       <= '0;
            ch_cnt        <= '0;
            run_cnt       <= '0;
            data_in_ready <= 1'b0;
            result        <= '0;
            result_valid  <= 1'b0;
            timeout_err   <= 1'b0;
            for (int c = 0; c < IC; c++) img_in[c] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        img_in[ch_cnt][pix_cnt] <= pix_in;
                        if (last_pix) begin
                            pix_cnt <= '0;
                            ch_cnt  <= last_ch ? '0 : ch_cnt + 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                    if (last_xfer) begin
                        data_in_ready <= 1'b1;
                        run_cnt       <= '0;
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (core_done) begin
                        // Dropping data_in_ready here keeps the core from restarting.
                        result        <= core_img_out;
                        result_valid  <= 1'b1;
                        data_in_ready <= 1'b0;
                    end else if (run_expired) begin
                        timeout_err   <= 1'b1;
                        data_in_ready <= 1'b0;
                        run_cnt       <= '0;
                        pix_cnt       <= '0;
                        ch_cnt        <= '0;
                    end
                end
                HOLD: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        pix_cnt      <= '0;
                        ch_cnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
